// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter in front of one shared 4-bit
// adder/subtractor. It captures the winning requester's operands and
// sequences them through the datapath (IDLE -> EXEC -> DONE). The result is
// returned tagged with the owner's index and a two's-complement overflow flag.
// Optional build macro: ADDSUB_ARB_PRIO0_EN gives requester 0 absolute
// priority, and the remaining requesters share round-robin.
module addsub_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    input  logic [NREQ-1:0]       op_sub,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  result_valid,
    output logic [IDW-1:0]        result_id,
    output logic [WIDTH-1:0]      result,
    output logic                  result_ovf
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW:0]     idx;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    // Winner select: search from last+1 and wrap around once.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
`ifdef ADDSUB_ARB_PRIO0_EN
        if (req[0]) begin
            found = 1'b1;
        end
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, last_q} + (IDW+1)'(i + 1);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    // Shared datapath: subtract is A + ~B + 1 and the carry out is dropped.
    always_comb begin
        b_eff = sub_q ? ~b_q : b_q;
        sum   = a_q + b_eff + {{(WIDTH-1){1'b0}}, sub_q};
        ovf   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Next-state and register-input logic for the operation sequencer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        gnt_d   = '0;
        rv_d    = 1'b0;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    a_d     = op_a[int'(win)*WIDTH +: WIDTH];
                    b_d     = op_b[int'(win)*WIDTH +: WIDTH];
                    sub_d   = op_sub[win];
                    id_d    = win;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    state_d = EXEC;
`ifdef ADDSUB_ARB_PRIO0_EN
                    // Requester 0 grants leave the rotation of the others untouched.
                    if (win != '0) begin
                        last_d = win;
                    end
`else
                    last_d = win;
`endif
                end
            end
            EXEC: begin
                res_d   = sum;
                ovf_d   = ovf;
                rv_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            gnt_q   <= '0;
            rv_q    <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            gnt_q   <= gnt_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign gnt          = gnt_q;
    assign busy         = (state_q != IDLE);
    assign result_valid = rv_q;
    assign result_id    = id_q;
    assign result       = res_q;
    assign result_ovf   = ovf_q;

endmodule
